// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared definitions for the CTI-8 bus transfer sequencer: FSM encodings, default widths and
// a small index range helper.
package bus_transfer_sequencer_pkg;

  localparam int unsigned DefaultNumRegs = 4;
  localparam int unsigned DefaultDataW   = 8;
  localparam int unsigned DefaultIdxW    = 2;

  localparam int unsigned StateW = 2;

  localparam logic [StateW-1:0] StIdle  = 2'd0;
  localparam logic [StateW-1:0] StDrive = 2'd1;
  localparam logic [StateW-1:0] StWrite = 2'd2;
  localparam logic [StateW-1:0] StTurn  = 2'd3;

  function automatic logic idx_valid(input int unsigned idx, input int unsigned num);
    return idx < num;
  endfunction

endpackage

// File: rtl/bus_transfer_sequencer_onehot_decoder.sv
// Index to one-hot decoder with enable; indices outside the output range decode to all zeros.
module bus_transfer_sequencer_onehot_decoder #(
  parameter int unsigned NumOut = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic              en_i,
  input  logic [IdxW-1:0]   idx_i,
  output logic [NumOut-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NumOut; i++) begin
      if (en_i && (32'(idx_i) == i)) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences one register-to-register or immediate-to-register move over the shared tri-state
// data bus: DRIVE, WRITE, then a TURN cycle so ownership changes never overlap.
module bus_transfer_sequencer
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int unsigned NumRegs = DefaultNumRegs,
  parameter int unsigned DataW   = DefaultDataW,
  parameter int unsigned IdxW    = DefaultIdxW
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [IdxW-1:0]    req_src_i,
  input  logic [IdxW-1:0]    req_dst_i,
  input  logic               req_imm_en_i,
  input  logic [DataW-1:0]   req_imm_i,
  output logic [NumRegs-1:0] reg_oe_o,
  output logic [NumRegs-1:0] reg_wr_o,
  inout  wire  [DataW-1:0]   data_bus_io,
  output logic [DataW-1:0]   xfer_data_o,
  output logic               done_o,
  output logic               err_o
);

  logic [StateW-1:0] state_q, state_d;
  logic [IdxW-1:0]   src_q, dst_q;
  logic              imm_en_q;
  logic [DataW-1:0]  imm_q;
  logic [DataW-1:0]  xfer_q;
  logic              err_q, err_d;

  logic accept;
  logic bad_idx;
  logic is_noop;
  logic src_active;
  logic imm_drv;

  assign accept  = req_valid_i && (state_q == StIdle);
  // The source index only matters when a register, not the immediate, drives the bus.
  assign bad_idx = (!req_imm_en_i && !idx_valid(32'(req_src_i), NumRegs)) ||
                   !idx_valid(32'(req_dst_i), NumRegs);
  assign is_noop = !req_imm_en_i && (req_src_i == req_dst_i);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          err_d   = bad_idx;
          state_d = (bad_idx || is_noop) ? StTurn : StDrive;
        end
      end
      StDrive: state_d = StWrite;
      StWrite: state_d = StTurn;
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      xfer_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        src_q    <= req_src_i;
        dst_q    <= req_dst_i;
        imm_en_q <= req_imm_en_i;
        imm_q    <= req_imm_i;
      end
      if (state_q == StWrite) begin
        xfer_q <= data_bus_io;
      end
    end
  end

  // The source drives through both DRIVE and WRITE so the bus is settled before wr rises.
  assign src_active = (state_q == StDrive) || (state_q == StWrite);
  assign imm_drv    = src_active && imm_en_q;

  bus_transfer_sequencer_onehot_decoder #(
    .NumOut(NumRegs),
    .IdxW  (IdxW)
  ) u_oe_dec (
    .en_i    (src_active && !imm_en_q),
    .idx_i   (src_q),
    .onehot_o(reg_oe_o)
  );

  bus_transfer_sequencer_onehot_decoder #(
    .NumOut(NumRegs),
    .IdxW  (IdxW)
  ) u_wr_dec (
    .en_i    (state_q == StWrite),
    .idx_i   (dst_q),
    .onehot_o(reg_wr_o)
  );

  assign data_bus_io = imm_drv ? imm_q : {DataW{1'bz}};

  assign req_ready_o = (state_q == StIdle);
  assign done_o      = (state_q == StTurn);
  assign err_o       = (state_q == StTurn) && err_q;
  assign xfer_data_o = xfer_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: directed scenarios plus random moves against a register
// bank model, with four attached bench-side registers sharing the tri-state bus.
module tb_bus_transfer_sequencer;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_src = '0;
  logic [IW-1:0] req_dst = '0;
  logic          req_imm_en = 1'b0;
  logic [DW-1:0] req_imm = '0;
  logic [NR-1:0] reg_oe, reg_wr;
  wire  [DW-1:0] data_bus;
  logic [DW-1:0] xfer_data;
  logic          done, err;
  logic          probe_en = 1'b0;

  logic [DW-1:0] bank [NR];
  logic [DW-1:0] model_regs [NR];
  logic [DW-1:0] model_xfer;
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  bus_transfer_sequencer #(
    .NumRegs(NR),
    .DataW  (DW),
    .IdxW   (IW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_src_i   (req_src),
    .req_dst_i   (req_dst),
    .req_imm_en_i(req_imm_en),
    .req_imm_i   (req_imm),
    .reg_oe_o    (reg_oe),
    .reg_wr_o    (reg_wr),
    .data_bus_io (data_bus),
    .xfer_data_o (xfer_data),
    .done_o      (done),
    .err_o       (err)
  );

  // Attached registers: drive the bus on oe, capture on wr, cleared by system reset.
  for (genvar i = 0; i < NR; i++) begin : g_reg
    assign data_bus = reg_oe[i] ? bank[i] : {DW{1'bz}};
  end
  // Probe drives zero while idle so any stray driver shows up as a non-zero bus value.
  assign data_bus = probe_en ? {DW{1'b0}} : {DW{1'bz}};

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rst) bank[i] <= '0;
      else if (reg_wr[i]) bank[i] <= data_bus;
    end
  end

  always @(negedge clk) begin
    vectors++;
    if ($countones(reg_oe) > 1 || $countones(reg_wr) > 1) begin
      miscompares++;
      $display("FAIL single_driver: oe=%b wr=%b, need at most one bit each", reg_oe, reg_wr);
    end
  end

  function automatic logic [10:0] obs();
    return {reg_oe, reg_wr, done, err, req_ready};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    model_xfer = '0;
  endtask

  task automatic model_apply(input logic [IW-1:0] s, input logic [IW-1:0] d, input logic ie,
                             input logic [DW-1:0] im);
    logic [DW-1:0] v;
    if (!ie && s == d) return;
    v = ie ? im : model_regs[s];
    model_regs[d] = v;
    model_xfer = v;
  endtask

  // Issues one request from a falling edge; returns at the falling edge one cycle after handshake.
  task automatic send(input logic [IW-1:0] s, input logic [IW-1:0] d, input logic ie,
                      input logic [DW-1:0] im);
    int n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!req_ready) begin
      miscompares++;
      $display("FAIL ready_timeout: ready=%b, need 1", req_ready);
    end
    req_valid = 1'b1; req_src = s; req_dst = d; req_imm_en = ie; req_imm = im;
    model_apply(s, d, ie, im);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic probe_bus(input string name);
    probe_en = 1'b1;
    #1;
    vectors++;
    if (data_bus !== 8'h00) begin
      miscompares++;
      $display("FAIL %s: bus=%h with probe at 00, need 00 (bus released)", name, data_bus);
    end
    probe_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++;
    if (obs() !== 11'b0000_0000_001) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, need 00000000001", obs());
    end
    vectors++;
    if (xfer_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_xfer: got %h, need 00", xfer_data);
    end
    probe_bus("reset_bus");
  endtask

  task automatic test_imm_move();
    send(2'd0, 2'd1, 1'b1, 8'h42);
    vectors++;
    if (obs() !== 11'b0000_0000_000 || data_bus !== 8'h42) begin
      miscompares++;
      $display("FAIL imm_drive: got %b bus=%h, need 00000000000 bus=42", obs(), data_bus);
    end
    @(negedge clk);
    vectors++;
    if (obs() !== 11'b0000_0010_000 || data_bus !== 8'h42) begin
      miscompares++;
      $display("FAIL imm_write: got %b bus=%h, need 00000010000 bus=42", obs(), data_bus);
    end
    @(negedge clk);
    vectors++;
    if (obs() !== 11'b0000_0000_100 || xfer_data !== 8'h42) begin
      miscompares++;
      $display("FAIL imm_turn: got %b xfer=%h, need 00000000100 xfer=42", obs(), xfer_data);
    end
    @(negedge clk);
    vectors++;
    if (obs() !== 11'b0000_0000_001 || bank[1] !== 8'h42) begin
      miscompares++;
      $display("FAIL imm_done: got %b R1=%h, need 00000000001 R1=42", obs(), bank[1]);
    end
  endtask

  task automatic test_reg_move();
    send(2'd1, 2'd3, 1'b0, 8'h00);
    vectors++;
    if (obs() !== 11'b0010_0000_000 || data_bus !== 8'h42) begin
      miscompares++;
      $display("FAIL reg_drive: got %b bus=%h, need 00100000000 bus=42", obs(), data_bus);
    end
    @(negedge clk);
    vectors++;
    if (obs() !== 11'b0010_1000_000) begin
      miscompares++;
      $display("FAIL reg_write: got %b, need 00101000000", obs());
    end
    @(negedge clk);
    vectors++;
    if (obs() !== 11'b0000_0000_100) begin
      miscompares++;
      $display("FAIL reg_turn: got %b, need 00000000100", obs());
    end
    @(negedge clk);
    vectors++;
    if (obs() !== 11'b0000_0000_001 || bank[3] !== 8'h42 || xfer_data !== 8'h42) begin
      miscompares++;
      $display("FAIL reg_done: got %b R3=%h xfer=%h, need 00000000001 R3=42 xfer=42",
               obs(), bank[3], xfer_data);
    end
  endtask

  task automatic test_noop();
    send(2'd2, 2'd2, 1'b0, 8'hA5);
    vectors++;
    if (obs() !== 11'b0000_0000_100 || xfer_data !== 8'h42) begin
      miscompares++;
      $display("FAIL noop_turn: got %b xfer=%h, need 00000000100 xfer=42", obs(), xfer_data);
    end
    probe_bus("noop_bus");
    @(negedge clk);
    vectors++;
    if (obs() !== 11'b0000_0000_001 || bank[2] !== 8'h00) begin
      miscompares++;
      $display("FAIL noop_idle: got %b R2=%h, need 00000000001 R2=00", obs(), bank[2]);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    req_valid = 1'b1; req_imm_en = 1'b1; req_src = 2'd0; req_dst = 2'd0; req_imm = 8'hAA;
    for (int c = 0; c < 12 && second < 0; c++) begin
      if (req_ready) begin
        if (first < 0) begin
          first = c;
          model_apply(2'd0, 2'd0, 1'b1, 8'hAA);
        end else begin
          second = c;
          model_apply(2'd0, 2'd2, 1'b0, 8'h00);
        end
      end
      @(negedge clk);
      if (first >= 0 && second < 0) begin
        req_imm_en = 1'b0; req_src = 2'd0; req_dst = 2'd2;
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (second < 0 || second - first != 4) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d cycles, need 4", second - first);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bank[2] !== 8'hAA || xfer_data !== 8'hAA || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_result: R2=%h xfer=%h ready=%b, need AA AA 1", bank[2], xfer_data,
               req_ready);
    end
  endtask

  task automatic test_reset_mid_move();
    send(2'd0, 2'd0, 1'b1, 8'h55);
    @(negedge clk);
    vectors++;
    if (reg_wr !== 4'b0001) begin
      miscompares++;
      $display("FAIL mid_write: wr=%b, need 0001", reg_wr);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs() !== 11'b0000_0000_001 || xfer_data !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: got %b xfer=%h, need 00000000001 xfer=00", obs(), xfer_data);
    end
    probe_bus("mid_reset_bus");
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || reg_wr !== 4'b0000) begin
        miscompares++;
        $display("FAIL mid_no_done: done=%b wr=%b, need 0 0000", done, reg_wr);
      end
    end
  endtask

  task automatic test_random();
    logic [IW-1:0] s, d;
    logic          ie;
    logic [DW-1:0] im, v;
    logic [NR-1:0] exp_oe, exp_wr;
    logic          normal;
    int            last;
    for (int k = 0; k < 40; k++) begin
      s = IW'($urandom_range(0, NR - 1));
      d = IW'($urandom_range(0, NR - 1));
      ie = 1'($urandom_range(0, 1));
      im = DW'($urandom);
      normal = ie || (s != d);
      v = ie ? im : model_regs[s];
      last = normal ? 4 : 2;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(s, d, ie, im);
      for (int c = 1; c <= last; c++) begin
        if (c > 1) @(negedge clk);
        exp_oe = (normal && c <= 2 && !ie) ? (4'b0001 << s) : 4'b0000;
        exp_wr = (normal && c == 2) ? (4'b0001 << d) : 4'b0000;
        vectors++;
        if (obs() !== {exp_oe, exp_wr, (c == last - 1), 1'b0, (c == last)}) begin
          miscompares++;
          $display("FAIL rand_trace k=%0d c=%0d: got %b, need %b", k, c, obs(),
                   {exp_oe, exp_wr, (c == last - 1), 1'b0, (c == last)});
        end
        if (normal && c <= 2) begin
          vectors++;
          if (data_bus !== v) begin
            miscompares++;
            $display("FAIL rand_bus k=%0d c=%0d: got %h, need %h", k, c, data_bus, v);
          end
        end
      end
      vectors++;
      if (xfer_data !== model_xfer || bank[d] !== model_regs[d]) begin
        miscompares++;
        $display("FAIL rand_result k=%0d: xfer=%h R%0d=%h, need xfer=%h R=%h", k, xfer_data,
                 d, bank[d], model_xfer, model_regs[d]);
      end
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_imm_move();
    test_reg_move();
    test_noop();
    test_back_to_back();
    test_reset_mid_move();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
